// File: rtl/pipeline_control_if.sv
// Control/status bundle between the pipeline controller (master) and the datapath (slave).
interface pipeline_control_if;
    logic       run;
    logic       halt_req;
    logic [1:0] id_s;
    logic       id_wr_cf;
    logic       alu_cf;
    logic       ex_ld_a;
    logic       ex_ld_b;
    logic       ex_ld_pc;
    logic       if_valid;
    logic       id_valid;
    logic       ex_valid;
    logic       stall;
    logic       flush;
    logic       pc_en;
    logic       fwd_a;
    logic       fwd_b;
    logic       dcf;
    logic       cf;
    logic [1:0] state;
    logic [7:0] retired;

    modport master (
        input  run, halt_req, id_s, id_wr_cf, alu_cf, ex_ld_a, ex_ld_b, ex_ld_pc,
        output if_valid, id_valid, ex_valid, stall, flush, pc_en, fwd_a, fwd_b,
               dcf, cf, state, retired
    );

    modport slave (
        output run, halt_req, id_s, id_wr_cf, alu_cf, ex_ld_a, ex_ld_b, ex_ld_pc,
        input  if_valid, id_valid, ex_valid, stall, flush, pc_en, fwd_a, fwd_b,
               dcf, cf, state, retired
    );
endinterface

// File: rtl/pipeline_control.sv
// Run/halt sequencing, stage valids, hazard stall/forward, carry flag and retire count
// for the 3-stage 4-bit CPU pipeline.
module pipeline_control #(
    parameter bit FORWARD = 1'b1
) (
    input logic                clk,
    input logic                rst,
    pipeline_control_if.master bus
);
    localparam int unsigned RETIRED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 if_v_q;
    logic                 id_v_q;
    logic                 ex_v_q;
    logic                 cf_q;
    logic [RETIRED_W-1:0] retired_q;

    logic fetch;
    logic hz;
    logic flush_c;
    logic stall_c;
    logic cf_wr;

    // Hazard and sequencing decode from registered state and current inputs
    always_comb begin
        fetch   = (state_q == ST_RUN) && !bus.halt_req;
        hz      = id_v_q && ex_v_q &&
                  (((bus.id_s == 2'd0) && bus.ex_ld_a) ||
                   ((bus.id_s == 2'd1) && bus.ex_ld_b));
        flush_c = ex_v_q && bus.ex_ld_pc;
        stall_c = !FORWARD && hz && !flush_c;
        cf_wr   = id_v_q && bus.id_wr_cf && !stall_c && !flush_c;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.run)      state_d = ST_RUN;
            ST_RUN:    if (bus.halt_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (!if_v_q && !id_v_q && !ex_v_q) state_d = ST_HALTED;
            ST_HALTED: if (bus.run)      state_d = ST_RUN;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Stage valids, carry flag and retire counter; flush outranks stall
    always_ff @(posedge clk) begin
        if (rst) begin
            if_v_q    <= 1'b0;
            id_v_q    <= 1'b0;
            ex_v_q    <= 1'b0;
            cf_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            if (flush_c) begin
                if_v_q <= 1'b0;
                id_v_q <= 1'b0;
                ex_v_q <= 1'b0;
            end else if (stall_c) begin
                ex_v_q <= 1'b0;
            end else begin
                if_v_q <= fetch;
                id_v_q <= if_v_q;
                ex_v_q <= id_v_q;
            end
            if (cf_wr) cf_q <= bus.alu_cf;
            if (ex_v_q) retired_q <= retired_q + RETIRED_W'(1);
        end
    end

    // Combinational controls are forced quiet while reset is held so no write commits
    assign bus.flush    = !rst && flush_c;
    assign bus.stall    = !rst && stall_c;
    assign bus.pc_en    = !rst && (flush_c || (fetch && !stall_c));
    assign bus.fwd_a    = !rst && FORWARD && hz && (bus.id_s == 2'd0);
    assign bus.fwd_b    = !rst && FORWARD && hz && (bus.id_s == 2'd1);
    assign bus.dcf      = !rst && ((id_v_q && bus.id_wr_cf) ? bus.alu_cf : cf_q);

    assign bus.if_valid = if_v_q;
    assign bus.id_valid = id_v_q;
    assign bus.ex_valid = ex_v_q;
    assign bus.cf       = cf_q;
    assign bus.state    = state_q;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench: forwarding (u_f) and stalling (u_s) controllers driven with identical inputs.
module tb_pipeline_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    pipeline_control_if if_f ();
    pipeline_control_if if_s ();

    pipeline_control #(.FORWARD(1'b1)) u_f (.clk(clk), .rst(rst), .bus(if_f.master));
    pipeline_control #(.FORWARD(1'b0)) u_s (.clk(clk), .rst(rst), .bus(if_s.master));

    assign if_s.run      = if_f.run;
    assign if_s.halt_req = if_f.halt_req;
    assign if_s.id_s     = if_f.id_s;
    assign if_s.id_wr_cf = if_f.id_wr_cf;
    assign if_s.alu_cf   = if_f.alu_cf;
    assign if_s.ex_ld_a  = if_f.ex_ld_a;
    assign if_s.ex_ld_b  = if_f.ex_ld_b;
    assign if_s.ex_ld_pc = if_f.ex_ld_pc;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic h, input logic [1:0] s, input logic wr,
                         input logic alu, input logic la, input logic lb, input logic lpc);
        if_f.run      = r;
        if_f.halt_req = h;
        if_f.id_s     = s;
        if_f.id_wr_cf = wr;
        if_f.alu_cf   = alu;
        if_f.ex_ld_a  = la;
        if_f.ex_ld_b  = lb;
        if_f.ex_ld_pc = lpc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (if_f.state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", if_f.state); end
        n_cmp++; if ({if_f.if_valid, if_f.id_valid, if_f.ex_valid} !== 3'b000) begin n_bad++;
            $display("FAIL reset_valids got %b want 000", {if_f.if_valid, if_f.id_valid, if_f.ex_valid}); end
        n_cmp++; if (if_f.cf !== 1'b0) begin n_bad++; $display("FAIL reset_cf got %b want 0", if_f.cf); end
        n_cmp++; if (if_f.retired !== 8'd0) begin n_bad++; $display("FAIL reset_retired got %0d want 0", if_f.retired); end
        n_cmp++; if ({if_f.stall, if_f.flush, if_f.pc_en, if_f.fwd_a, if_f.fwd_b, if_f.dcf} !== 6'b0) begin n_bad++;
            $display("FAIL reset_comb got %b want 000000", {if_f.stall, if_f.flush, if_f.pc_en, if_f.fwd_a, if_f.fwd_b, if_f.dcf}); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Five fetches, then halt; edge-by-edge expectations from the RUN edge onward
    task automatic test_straight_line();
        logic [1:0] exp_st [0:9];
        logic [2:0] exp_v  [0:9];
        logic [7:0] exp_r  [0:9];
        logic       exp_pc;
        exp_st = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
        exp_v  = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b111, 3'b111, 3'b011, 3'b001, 3'b000, 3'b000};
        exp_r  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5};
        for (int k = 0; k < 10; k++) begin
            drive(k < 6, k >= 6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_pc = (k >= 1) && (k <= 5);
            n_cmp++; if (if_f.pc_en !== exp_pc) begin n_bad++; $display("FAIL straight_pc_en k=%0d got %b want %b", k, if_f.pc_en, exp_pc); end
            n_cmp++; if ({if_f.stall, if_f.flush} !== 2'b00) begin n_bad++;
                $display("FAIL straight_stall_flush k=%0d got %b want 00", k, {if_f.stall, if_f.flush}); end
            tick();
            n_cmp++; if (if_f.state !== exp_st[k]) begin n_bad++; $display("FAIL straight_state k=%0d got %0d want %0d", k, if_f.state, exp_st[k]); end
            n_cmp++; if ({if_f.if_valid, if_f.id_valid, if_f.ex_valid} !== exp_v[k]) begin n_bad++;
                $display("FAIL straight_valids k=%0d got %b want %b", k, {if_f.if_valid, if_f.id_valid, if_f.ex_valid}, exp_v[k]); end
            n_cmp++; if (if_f.retired !== exp_r[k]) begin n_bad++; $display("FAIL straight_retired k=%0d got %0d want %0d", k, if_f.retired, exp_r[k]); end
        end
        n_cmp++; if (if_s.retired !== 8'd5) begin n_bad++; $display("FAIL straight_retired_s got %0d want 5", if_s.retired); end
    endtask

    // Resume from HALTED, refill, then halt with RUN still held
    task automatic test_halt_resume();
        logic [2:0] exp_v [0:2];
        exp_v = '{3'b011, 3'b001, 3'b000};
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (if_f.pc_en !== 1'b0) begin n_bad++; $display("FAIL halted_pc_en got %b want 0", if_f.pc_en); end
        tick();
        n_cmp++; if (if_f.state !== 2'd1) begin n_bad++; $display("FAIL resume_state got %0d want 1", if_f.state); end
        tick();
        n_cmp++; if (if_f.if_valid !== 1'b1) begin n_bad++; $display("FAIL resume_if_valid got %b want 1", if_f.if_valid); end
        tick();
        tick();
        n_cmp++; if ({if_f.if_valid, if_f.id_valid, if_f.ex_valid, if_f.retired} !== {3'b111, 8'd5}) begin n_bad++;
            $display("FAIL refill got %b/%0d want 111/5", {if_f.if_valid, if_f.id_valid, if_f.ex_valid}, if_f.retired); end
        drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (if_f.pc_en !== 1'b0) begin n_bad++; $display("FAIL drain_pc_en i=%0d got %b want 0", i, if_f.pc_en); end
            tick();
            n_cmp++; if (if_f.state !== 2'd2) begin n_bad++; $display("FAIL drain_state i=%0d got %0d want 2", i, if_f.state); end
            n_cmp++; if ({if_f.if_valid, if_f.id_valid, if_f.ex_valid} !== exp_v[i]) begin n_bad++;
                $display("FAIL drain_valids i=%0d got %b want %b", i, {if_f.if_valid, if_f.id_valid, if_f.ex_valid}, exp_v[i]); end
        end
        n_cmp++; if (if_f.retired !== 8'd8) begin n_bad++; $display("FAIL drain_retired got %0d want 8", if_f.retired); end
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (if_f.state !== 2'd3) begin n_bad++; $display("FAIL halted_state got %0d want 3", if_f.state); end
    endtask

    task automatic test_jump();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if ({if_f.flush, if_f.pc_en} !== 2'b11) begin n_bad++;
            $display("FAIL jump_flush_pc got %b want 11", {if_f.flush, if_f.pc_en}); end
        tick();
        n_cmp++; if ({if_f.if_valid, if_f.id_valid, if_f.ex_valid, if_f.retired} !== {3'b000, 8'd9}) begin n_bad++;
            $display("FAIL jump_after got %b/%0d want 000/9", {if_f.if_valid, if_f.id_valid, if_f.ex_valid}, if_f.retired); end
        n_cmp++; if (if_f.flush !== 1'b0) begin n_bad++; $display("FAIL jump_flush_once got %b want 0", if_f.flush); end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (if_f.if_valid !== 1'b1) begin n_bad++; $display("FAIL jump_refetch got %b want 1", if_f.if_valid); end
    endtask

    task automatic test_forward_stall();
        logic [7:0] rf;
        logic [7:0] rs;
        tick();
        tick();
        rf = if_f.retired;
        rs = if_s.retired;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if ({if_f.fwd_a, if_f.fwd_b, if_f.stall, if_f.pc_en} !== 4'b1001) begin n_bad++;
            $display("FAIL fwd_a got %b want 1001", {if_f.fwd_a, if_f.fwd_b, if_f.stall, if_f.pc_en}); end
        n_cmp++; if ({if_s.stall, if_s.fwd_a, if_s.pc_en} !== 3'b100) begin n_bad++;
            $display("FAIL stall_a got %b want 100", {if_s.stall, if_s.fwd_a, if_s.pc_en}); end
        tick();
        n_cmp++; if ({if_s.if_valid, if_s.id_valid, if_s.ex_valid, if_s.stall} !== 4'b1100) begin n_bad++;
            $display("FAIL stall_bubble got %b want 1100", {if_s.if_valid, if_s.id_valid, if_s.ex_valid, if_s.stall}); end
        n_cmp++; if ({if_f.if_valid, if_f.id_valid, if_f.ex_valid} !== 3'b111) begin n_bad++;
            $display("FAIL fwd_no_bubble got %b want 111", {if_f.if_valid, if_f.id_valid, if_f.ex_valid}); end
        tick();
        n_cmp++; if ({if_s.ex_valid, if_s.retired} !== {1'b1, rs + 8'd1}) begin n_bad++;
            $display("FAIL stall_proceed got %b/%0d want 1/%0d", if_s.ex_valid, if_s.retired, rs + 8'd1); end
        n_cmp++; if (if_f.retired !== rf + 8'd2) begin n_bad++; $display("FAIL fwd_retired got %0d want %0d", if_f.retired, rf + 8'd2); end
        drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if ({if_f.fwd_a, if_f.fwd_b, if_s.stall} !== 3'b011) begin n_bad++;
            $display("FAIL fwd_b got %b want 011", {if_f.fwd_a, if_f.fwd_b, if_s.stall}); end
        drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if ({if_f.fwd_a, if_f.fwd_b, if_s.stall} !== 3'b000) begin n_bad++;
            $display("FAIL no_hz_b_reads_a got %b want 000", {if_f.fwd_a, if_f.fwd_b, if_s.stall}); end
        drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if ({if_f.fwd_a, if_f.fwd_b, if_s.stall} !== 3'b000) begin n_bad++;
            $display("FAIL no_hz_s2 got %b want 000", {if_f.fwd_a, if_f.fwd_b, if_s.stall}); end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++; if ({if_s.stall, if_s.flush, if_s.pc_en} !== 3'b011) begin n_bad++;
            $display("FAIL flush_over_stall got %b want 011", {if_s.stall, if_s.flush, if_s.pc_en}); end
        tick();
        n_cmp++; if ({if_s.if_valid, if_s.id_valid, if_s.ex_valid} !== 3'b000) begin n_bad++;
            $display("FAIL flush_over_stall_valids got %b want 000", {if_s.if_valid, if_s.id_valid, if_s.ex_valid}); end
    endtask

    task automatic test_carry();
        drive(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (if_f.dcf !== 1'b0) begin n_bad++; $display("FAIL dcf_no_id got %b want 0", if_f.dcf); end
        tick();
        n_cmp++; if (if_f.cf !== 1'b0) begin n_bad++; $display("FAIL cf_no_id got %b want 0", if_f.cf); end
        tick();
        n_cmp++; if (if_f.dcf !== 1'b1) begin n_bad++; $display("FAIL dcf_fwd got %b want 1", if_f.dcf); end
        tick();
        n_cmp++; if ({if_f.cf, if_s.cf} !== 2'b11) begin n_bad++; $display("FAIL cf_update got %b want 11", {if_f.cf, if_s.cf}); end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (if_f.dcf !== 1'b1) begin n_bad++; $display("FAIL dcf_is_cf got %b want 1", if_f.dcf); end
        drive(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if ({if_f.dcf, if_s.stall} !== 2'b01) begin n_bad++; $display("FAIL dcf_clear got %b want 01", {if_f.dcf, if_s.stall}); end
        tick();
        n_cmp++; if ({if_f.cf, if_s.cf} !== 2'b01) begin n_bad++; $display("FAIL cf_stall_hold got %b want 01", {if_f.cf, if_s.cf}); end
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_drain();
        logic found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (if_f.retired == 8'd198) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL reach_198 got %0d want 198", if_f.retired); end
        drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        n_cmp++; if ({if_f.state, if_f.retired} !== {2'd2, 8'd200}) begin n_bad++;
            $display("FAIL pre_rst got %0d/%0d want 2/200", if_f.state, if_f.retired); end
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if ({if_f.flush, if_f.pc_en, if_s.dcf} !== 3'b000) begin n_bad++;
            $display("FAIL rst_comb got %b want 000", {if_f.flush, if_f.pc_en, if_s.dcf}); end
        tick();
        n_cmp++; if ({if_f.state, if_f.if_valid, if_f.id_valid, if_f.ex_valid, if_f.cf, if_f.retired} !== {2'd0, 4'b0000, 8'd0}) begin n_bad++;
            $display("FAIL rst_drain_f got %0d/%b/%b/%0d want 0/000/0/0", if_f.state,
                     {if_f.if_valid, if_f.id_valid, if_f.ex_valid}, if_f.cf, if_f.retired); end
        n_cmp++; if ({if_s.state, if_s.cf, if_s.retired} !== {2'd0, 1'b0, 8'd0}) begin n_bad++;
            $display("FAIL rst_drain_s got %0d/%b/%0d want 0/0/0", if_s.state, if_s.cf, if_s.retired); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        int cnt = 0;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            tick();
            cnt++;
            if (if_f.retired == 8'd255) break;
        end
        n_cmp++; if (cnt !== 259) begin n_bad++; $display("FAIL wrap_cycles got %0d want 259", cnt); end
        tick();
        n_cmp++; if (if_f.retired !== 8'd0) begin n_bad++; $display("FAIL wrap_zero got %0d want 0", if_f.retired); end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_halt_resume();
        test_jump();
        test_forward_stall();
        test_carry();
        test_reset_in_drain();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
